tank_ctrl: RTL and testbench
============================

Name: tank_ctrl

Overview:
Parametrised player-tank controller. Decodes a 4-byte USB keycode word into movement and fire commands, and keeps a tank position clamped to the arena with a facing direction. Owns one projectile, sequenced by a fire/flight/cooldown FSM. Instantiated once per player; outputs feed the sprite/colour mapper.

Parameters:
X_CENTER, 320, tank reset X (centre coordinate)
Y_CENTER, 240, tank reset Y
X_MIN / X_MAX, 0 / 639, arena horizontal bounds, inclusive
Y_MIN / Y_MAX, 0 / 479, arena vertical bounds, inclusive
TANK_SIZE, 16, tank half-extent in pixels
TANK_STEP, 1, tank pixels per frame
SHOT_STEP, 4, projectile pixels per frame
SHOT_LIFE, 120, projectile lifetime in frames
COOLDOWN, 30, frames after shot ends before re-arm
KEY_UP / KEY_DOWN / KEY_LEFT / KEY_RIGHT / KEY_FIRE, 8'h1A / 8'h16 / 8'h04 / 8'h07 / 8'h2C, USB usage codes

Ports:
frame_clk  in  1   frame-rate clock (vsync)
Reset      in  1   asynchronous, active-high reset
keycode    in  32  four concurrent key bytes; 8'h00 = none
tank_x     out 10  tank centre X
tank_y     out 10  tank centre Y
tank_s     out 10  TANK_SIZE constant
tank_dir   out 2   facing direction: 0 up, 1 right, 2 down, 3 left
shot_x     out 10  projectile X (valid when shot_active)
shot_y     out 10  projectile Y
shot_active out 1  projectile in flight

Behaviour:
- Reset: asynchronous, active-high. Drives tank_x=X_CENTER, tank_y=Y_CENTER, tank_dir=0, shot_active=0, shot_x=shot_y=0, FSM=IDLE, counters=0, fire_prev=0. Reset mid-flight aborts the shot immediately.
- Key decode (combinational): a key is pressed if any of the 4 bytes equals its code. Movement priority when several are held: UP > DOWN > LEFT > RIGHT; only one axis moves per frame.
- Tank motion: computed and applied in the same frame as the key, so there is no one-frame motion lag. Arithmetic uses 11-bit signed intermediates. Legal centre range is [X_MIN+TANK_SIZE, X_MAX-TANK_SIZE], and likewise for Y. A move that would exceed the range saturates at the limit; there is no bounce and no wrap. tank_dir updates to the pressed direction even when the move is clamped. With no movement key held, position and direction hold.
- Fire: rising edge only (fire_pressed & ~fire_prev). Holding fire does not auto-repeat.
- Shot FSM states IDLE, FLY, COOL:
  - IDLE: on a fire edge, load shot = pre-move tank centre offset by TANK_SIZE along tank_dir. Latch shot_dir=tank_dir, life=SHOT_LIFE-1, shot_active=1. Go to FLY on the next edge.
  - FLY: each frame advance SHOT_STEP along shot_dir. If the next position leaves [MIN,MAX], or life==0, then shot_active=0, cnt=COOLDOWN-1, go to COOL. Otherwise decrement life.
  - COOL: decrement cnt; at cnt==0 go to IDLE. Fire edges during FLY/COOL are dropped, not queued.
- Simultaneous movement and fire in one frame: the tank moves and the shot spawns from the old position.
- A spawn point outside the arena (tank at the edge facing it): the shot is not launched, and the FSM goes straight to COOL.

Optional Feature:
TANK_SHOT_BOUNCE_EN
- Defined: in FLY, a next position that would leave the arena instead reflects. shot_dir inverts on the violated axis, and position becomes boundary minus overshoot. Only life expiry ends the shot.
- Undefined: a boundary exit ends the shot as described in Behaviour.

Decomposition:
- tank_pkg holds:
  - dir_t enum (DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT)
  - shot_state_t enum (IDLE, FLY, COOL)
  - COORD_W=10 and default keycode localparams
- Sub-module key_match: 32-bit keycode plus an 8-bit code, producing a 1-bit hit. Instantiated five times.

Test Plan:
1. Assert Reset, then release with keycode=0. Expect tank (320,240), dir=0, shot_active=0, tank_s=16; stable for 10 frames.
2. Hold keycode=32'h0000001A for 3 frames → tank_y=237, dir=0. Hold 32'h04071600 (LEFT+RIGHT+DOWN) for 1 frame → tank_y=238, dir=2, tank_x unchanged.
3. Hold LEFT for 400 frames → tank_x saturates at 16, dir=3; no wrap past 0.
4. From reset, press 8'h2C for 1 frame → shot at (320,224), active. After 4 more frames shot_y=208. Holding fire throughout produces no second shot. Shot ends at y<0 boundary, then 30-frame cooldown, then a fire edge launches a new shot.
5. Fire facing right with SHOT_LIFE=5 and free space → shot_active high for exactly 5 frames. A fire edge during cooldown is ignored.
6. With TANK_SHOT_BOUNCE_EN: fire facing up from y=30 → the shot reflects at y=0 and its y then increases. Assert Reset mid-flight → shot_active=0 asynchronously.

Source files
------------

// File: rtl/tank_pkg.sv
// ============================================================================
// Module      : tank_pkg
// Description : Shared types, widths, default key codes and helpers for the
//               player-tank controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tank_pkg;

  localparam int COORD_W = 10;

  localparam logic [7:0] KEY_UP_DEF    = 8'h1A;
  localparam logic [7:0] KEY_DOWN_DEF  = 8'h16;
  localparam logic [7:0] KEY_LEFT_DEF  = 8'h04;
  localparam logic [7:0] KEY_RIGHT_DEF = 8'h07;
  localparam logic [7:0] KEY_FIRE_DEF  = 8'h2C;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } shot_state_t;

  function automatic logic signed [COORD_W:0] clamp_coord(
    input logic signed [COORD_W:0] v,
    input logic signed [COORD_W:0] lo,
    input logic signed [COORD_W:0] hi
  );
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  // Opposite direction on the same axis (bit 1 toggles up<->down, right<->left).
  function automatic dir_t dir_flip(input dir_t d);
    return dir_t'({~d[1], d[0]});
  endfunction

endpackage

`default_nettype wire

// File: rtl/tank_ctrl_key_match.sv
// ============================================================================
// Module      : key_match
// Description : Flags whether any of the four concurrent key bytes equals code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_match (
  input  logic [31:0] keycode,
  input  logic [7:0]  code,
  output logic        hit
);

  logic [3:0] byte_hit;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_byte
      assign byte_hit[i] = (keycode[8*i +: 8] == code);
    end
  endgenerate

  assign hit = |byte_hit;

endmodule

`default_nettype wire

// File: rtl/tank_ctrl.sv
// ============================================================================
// Module      : tank_ctrl
// Description : Player tank: key decode, clamped movement, one projectile with
//               fire/flight/cooldown sequencing. Define TANK_SHOT_BOUNCE_EN to
//               make the projectile reflect off the arena walls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tank_ctrl
  import tank_pkg::*;
#(
  parameter int         X_CENTER  = 320,
  parameter int         Y_CENTER  = 240,
  parameter int         X_MIN     = 0,
  parameter int         X_MAX     = 639,
  parameter int         Y_MIN     = 0,
  parameter int         Y_MAX     = 479,
  parameter int         TANK_SIZE = 16,
  parameter int         TANK_STEP = 1,
  parameter int         SHOT_STEP = 4,
  parameter int         SHOT_LIFE = 120,
  parameter int         COOLDOWN  = 30,
  parameter logic [7:0] KEY_UP    = KEY_UP_DEF,
  parameter logic [7:0] KEY_DOWN  = KEY_DOWN_DEF,
  parameter logic [7:0] KEY_LEFT  = KEY_LEFT_DEF,
  parameter logic [7:0] KEY_RIGHT = KEY_RIGHT_DEF,
  parameter logic [7:0] KEY_FIRE  = KEY_FIRE_DEF
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic [31:0]         keycode,
  output logic [COORD_W-1:0]  tank_x,
  output logic [COORD_W-1:0]  tank_y,
  output logic [COORD_W-1:0]  tank_s,
  output logic [1:0]          tank_dir,
  output logic [COORD_W-1:0]  shot_x,
  output logic [COORD_W-1:0]  shot_y,
  output logic                shot_active
);

  localparam int TW     = COORD_W + 1;
  // Shot math gets one more bit so wall reflection (2*MAX - pos) cannot wrap.
  localparam int SW     = COORD_W + 2;
  localparam int LIFE_W = $clog2(SHOT_LIFE + 1);
  localparam int CNT_W  = $clog2(COOLDOWN + 1);

  localparam logic signed [TW-1:0] TX_LO  = TW'(X_MIN + TANK_SIZE);
  localparam logic signed [TW-1:0] TX_HI  = TW'(X_MAX - TANK_SIZE);
  localparam logic signed [TW-1:0] TY_LO  = TW'(Y_MIN + TANK_SIZE);
  localparam logic signed [TW-1:0] TY_HI  = TW'(Y_MAX - TANK_SIZE);
  localparam logic signed [TW-1:0] T_STEP = TW'(TANK_STEP);

  localparam logic signed [SW-1:0] SX_MIN = SW'(X_MIN);
  localparam logic signed [SW-1:0] SX_MAX = SW'(X_MAX);
  localparam logic signed [SW-1:0] SY_MIN = SW'(Y_MIN);
  localparam logic signed [SW-1:0] SY_MAX = SW'(Y_MAX);
  localparam logic signed [SW-1:0] S_SIZE = SW'(TANK_SIZE);
  localparam logic signed [SW-1:0] S_STEP = SW'(SHOT_STEP);

  logic up_hit, down_hit, left_hit, right_hit, fire_hit;

  key_match u_key_up    (.keycode(keycode), .code(KEY_UP),    .hit(up_hit));
  key_match u_key_down  (.keycode(keycode), .code(KEY_DOWN),  .hit(down_hit));
  key_match u_key_left  (.keycode(keycode), .code(KEY_LEFT),  .hit(left_hit));
  key_match u_key_right (.keycode(keycode), .code(KEY_RIGHT), .hit(right_hit));
  key_match u_key_fire  (.keycode(keycode), .code(KEY_FIRE),  .hit(fire_hit));

  logic [COORD_W-1:0] pos_x, pos_y;
  dir_t               dir_q;
  logic               fire_prev;
  shot_state_t        state;
  logic [COORD_W-1:0] shot_x_q, shot_y_q;
  dir_t               shot_dir;
  logic [LIFE_W-1:0]  life;
  logic [CNT_W-1:0]   cnt;
  logic               shot_act;

  logic fire_edge;
  assign fire_edge = fire_hit & ~fire_prev;

  // Tank motion: one axis per frame, priority UP > DOWN > LEFT > RIGHT.
  logic signed [TW-1:0] cur_x, cur_y, nxt_x, nxt_y;
  dir_t                 nxt_dir;

  assign cur_x = signed'({1'b0, pos_x});
  assign cur_y = signed'({1'b0, pos_y});

  always_comb begin
    nxt_x   = cur_x;
    nxt_y   = cur_y;
    nxt_dir = dir_q;
    if (up_hit) begin
      nxt_dir = DIR_UP;
      nxt_y   = clamp_coord(cur_y - T_STEP, TY_LO, TY_HI);
    end else if (down_hit) begin
      nxt_dir = DIR_DOWN;
      nxt_y   = clamp_coord(cur_y + T_STEP, TY_LO, TY_HI);
    end else if (left_hit) begin
      nxt_dir = DIR_LEFT;
      nxt_x   = clamp_coord(cur_x - T_STEP, TX_LO, TX_HI);
    end else if (right_hit) begin
      nxt_dir = DIR_RIGHT;
      nxt_x   = clamp_coord(cur_x + T_STEP, TX_LO, TX_HI);
    end
  end

  // Spawn point uses the pre-move centre and facing.
  logic signed [SW-1:0] spawn_x, spawn_y;
  logic                 spawn_ok;

  always_comb begin
    spawn_x = signed'({2'b00, pos_x});
    spawn_y = signed'({2'b00, pos_y});
    case (dir_q)
      DIR_UP:    spawn_y = spawn_y - S_SIZE;
      DIR_RIGHT: spawn_x = spawn_x + S_SIZE;
      DIR_DOWN:  spawn_y = spawn_y + S_SIZE;
      default:   spawn_x = spawn_x - S_SIZE;
    endcase
  end

  assign spawn_ok = (spawn_x >= SX_MIN) && (spawn_x <= SX_MAX) &&
                    (spawn_y >= SY_MIN) && (spawn_y <= SY_MAX);

  logic signed [SW-1:0] adv_x, adv_y;

  always_comb begin
    adv_x = signed'({2'b00, shot_x_q});
    adv_y = signed'({2'b00, shot_y_q});
    case (shot_dir)
      DIR_UP:    adv_y = adv_y - S_STEP;
      DIR_RIGHT: adv_x = adv_x + S_STEP;
      DIR_DOWN:  adv_y = adv_y + S_STEP;
      default:   adv_x = adv_x - S_STEP;
    endcase
  end

`ifdef TANK_SHOT_BOUNCE_EN
  logic signed [SW-1:0] fly_x, fly_y;
  dir_t                 fly_dir;

  // Reflect the overshoot back inside and reverse along the violated axis.
  always_comb begin
    fly_x   = adv_x;
    fly_y   = adv_y;
    fly_dir = shot_dir;
    if (adv_x < SX_MIN) begin
      fly_x   = SX_MIN + SX_MIN - adv_x;
      fly_dir = dir_flip(shot_dir);
    end else if (adv_x > SX_MAX) begin
      fly_x   = SX_MAX + SX_MAX - adv_x;
      fly_dir = dir_flip(shot_dir);
    end
    if (adv_y < SY_MIN) begin
      fly_y   = SY_MIN + SY_MIN - adv_y;
      fly_dir = dir_flip(shot_dir);
    end else if (adv_y > SY_MAX) begin
      fly_y   = SY_MAX + SY_MAX - adv_y;
      fly_dir = dir_flip(shot_dir);
    end
  end
`else
  logic adv_out;
  assign adv_out = (adv_x < SX_MIN) || (adv_x > SX_MAX) ||
                   (adv_y < SY_MIN) || (adv_y > SY_MAX);
`endif

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      pos_x     <= COORD_W'(X_CENTER);
      pos_y     <= COORD_W'(Y_CENTER);
      dir_q     <= DIR_UP;
      fire_prev <= 1'b0;
      state     <= IDLE;
      shot_x_q  <= '0;
      shot_y_q  <= '0;
      shot_dir  <= DIR_UP;
      life      <= '0;
      cnt       <= '0;
      shot_act  <= 1'b0;
    end else begin
      fire_prev <= fire_hit;
      pos_x     <= COORD_W'(nxt_x);
      pos_y     <= COORD_W'(nxt_y);
      dir_q     <= nxt_dir;

      case (state)
        IDLE: begin
          if (fire_edge) begin
            if (spawn_ok) begin
              shot_x_q <= COORD_W'(spawn_x);
              shot_y_q <= COORD_W'(spawn_y);
              shot_dir <= dir_q;
              life     <= LIFE_W'(SHOT_LIFE - 1);
              shot_act <= 1'b1;
              state    <= FLY;
            end else begin
              cnt   <= CNT_W'(COOLDOWN - 1);
              state <= COOL;
            end
          end
        end

        FLY: begin
`ifdef TANK_SHOT_BOUNCE_EN
          if (life == '0) begin
            shot_act <= 1'b0;
            cnt      <= CNT_W'(COOLDOWN - 1);
            state    <= COOL;
          end else begin
            shot_x_q <= COORD_W'(fly_x);
            shot_y_q <= COORD_W'(fly_y);
            shot_dir <= fly_dir;
            life     <= life - LIFE_W'(1);
          end
`else
          if (adv_out || (life == '0)) begin
            shot_act <= 1'b0;
            cnt      <= CNT_W'(COOLDOWN - 1);
            state    <= COOL;
          end else begin
            shot_x_q <= COORD_W'(adv_x);
            shot_y_q <= COORD_W'(adv_y);
            life     <= life - LIFE_W'(1);
          end
`endif
        end

        COOL: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign tank_x      = pos_x;
  assign tank_y      = pos_y;
  assign tank_s      = COORD_W'(TANK_SIZE);
  assign tank_dir    = dir_q;
  assign shot_x      = shot_x_q;
  assign shot_y      = shot_y_q;
  assign shot_active = shot_act;

endmodule

`default_nettype wire

// File: tb/tb_tank_ctrl.sv
// ============================================================================
// Module      : tb_tank_ctrl
// Description : Directed checks of tank movement, firing and shot sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tank_ctrl;

  logic        frame_clk;
  logic        Reset;
  logic [31:0] keycode, keycode2;

  logic [9:0] tank_x, tank_y, tank_s, shot_x, shot_y;
  logic [1:0] tank_dir;
  logic       shot_active;

  logic [9:0] l_tank_x, l_tank_y, l_tank_s, l_shot_x, l_shot_y;
  logic [1:0] l_tank_dir;
  logic       l_shot_active;

  int checks = 0;
  int errors = 0;

  tank_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .tank_x(tank_x), .tank_y(tank_y), .tank_s(tank_s), .tank_dir(tank_dir),
    .shot_x(shot_x), .shot_y(shot_y), .shot_active(shot_active)
  );

  tank_ctrl #(.SHOT_LIFE(5), .COOLDOWN(4)) dut_life (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode2),
    .tank_x(l_tank_x), .tank_y(l_tank_y), .tank_s(l_tank_s), .tank_dir(l_tank_dir),
    .shot_x(l_shot_x), .shot_y(l_shot_y), .shot_active(l_shot_active)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] kc;
    int          frames;
    int          x;
    int          y;
    int          dir;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{32'h0000_0000,  10, 320, 240, 0};
    vecs[1]  = '{32'h0000_001A,   3, 320, 237, 0};
    vecs[2]  = '{32'h0407_1600,   1, 320, 238, 2};
    vecs[3]  = '{32'h0000_0007,   5, 325, 238, 1};
    vecs[4]  = '{32'h0000_0704,   2, 323, 238, 3};
    vecs[5]  = '{32'h0000_0004, 400,  16, 238, 3};
    vecs[6]  = '{32'h0000_0000,   2,  16, 238, 3};
    vecs[7]  = '{32'h0000_041A,   1,  16, 237, 0};
    vecs[8]  = '{32'h0000_0016, 300,  16, 463, 2};
    vecs[9]  = '{32'h0000_0007, 700, 623, 463, 1};
    vecs[10] = '{32'h0000_001A, 500, 623,  16, 0};

    Reset    = 1'b1;
    keycode  = 32'h0;
    keycode2 = 32'h0;
    repeat (2) @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    #1;

    chk("reset tank_x", tank_x, 320);
    chk("reset tank_y", tank_y, 240);
    chk("reset tank_dir", tank_dir, 0);
    chk("reset tank_s", tank_s, 16);
    chk("reset shot_active", shot_active, 0);
    chk("reset shot_x", shot_x, 0);
    chk("reset shot_y", shot_y, 0);

    for (int i = 0; i < 11; i++) begin
      keycode = vecs[i].kc;
      step(vecs[i].frames);
      chk($sformatf("vec%0d tank_x", i), tank_x, vecs[i].x);
      chk($sformatf("vec%0d tank_y", i), tank_y, vecs[i].y);
      chk($sformatf("vec%0d tank_dir", i), tank_dir, vecs[i].dir);
      chk($sformatf("vec%0d tank_s", i), tank_s, 16);
      chk($sformatf("vec%0d shot_active", i), shot_active, 0);
    end

    // Tank pinned at the top edge: spawn lands on y=0, first advance leaves.
    keycode = 32'h0;
    step(1);
    keycode = 32'h0000_002C;
    step(1);
    chk("edge spawn active", shot_active, 1);
    chk("edge spawn x", shot_x, 623);
    chk("edge spawn y", shot_y, 0);
    step(1);
    chk("edge spawn ends", shot_active, 0);
    keycode = 32'h0;
    do_reset();

    // Held fire from reset: one shot flies up to the wall.
    keycode = 32'h0000_002C;
    step(1);
    chk("fire spawn active", shot_active, 1);
    chk("fire spawn x", shot_x, 320);
    chk("fire spawn y", shot_y, 224);
    step(4);
    chk("fly 4 y", shot_y, 208);
    chk("fly 4 x", shot_x, 320);
    step(52);
    chk("at wall active", shot_active, 1);
    chk("at wall y", shot_y, 0);
`ifdef TANK_SHOT_BOUNCE_EN
    step(1);
    chk("bounce active", shot_active, 1);
    chk("bounce y1", shot_y, 4);
    step(1);
    chk("bounce y2", shot_y, 8);
`else
    step(1);
    chk("wall exit", shot_active, 0);
    keycode = 32'h0;
    step(1);
    keycode = 32'h0000_002C;
    step(1);
    chk("cool fire dropped", shot_active, 0);
    keycode = 32'h0;
    step(27);
    chk("cool still idle", shot_active, 0);
    keycode = 32'h0000_002C;
    step(1);
    chk("last cool frame fire dropped", shot_active, 0);
    keycode = 32'h0;
    step(1);
    keycode = 32'h0000_002C;
    step(1);
    chk("rearm fire active", shot_active, 1);
    chk("rearm fire y", shot_y, 224);
`endif
    keycode = 32'h0;
    do_reset();

    // Asynchronous reset in mid-flight.
    keycode = 32'h0000_002C;
    step(1);
    keycode = 32'h0;
    step(3);
    chk("pre-reset active", shot_active, 1);
    chk("pre-reset y", shot_y, 212);
    Reset = 1'b1;
    #1;
    chk("async reset active", shot_active, 0);
    chk("async reset tank_y", tank_y, 240);
    chk("async reset shot_y", shot_y, 0);
    Reset = 1'b0;
    step(1);

    // Move and fire together: tank moves, shot uses old centre and facing.
    keycode = 32'h0000_2C07;
    step(1);
    chk("move+fire tank_x", tank_x, 321);
    chk("move+fire tank_dir", tank_dir, 1);
    chk("move+fire shot_active", shot_active, 1);
    chk("move+fire shot_x", shot_x, 320);
    chk("move+fire shot_y", shot_y, 224);
    keycode = 32'h0;
    do_reset();

    // Short-life instance: five active frames, cooldown drops fire.
    keycode2 = 32'h0000_0007;
    step(1);
    keycode2 = 32'h0000_002C;
    step(1);
    chk("life spawn active", l_shot_active, 1);
    chk("life spawn x", l_shot_x, 337);
    chk("life spawn y", l_shot_y, 240);
    keycode2 = 32'h0;
    step(4);
    chk("life frame5 active", l_shot_active, 1);
    chk("life frame5 x", l_shot_x, 353);
    step(1);
    chk("life expired", l_shot_active, 0);
    step(1);
    keycode2 = 32'h0000_002C;
    step(1);
    chk("life cool fire dropped", l_shot_active, 0);
    keycode2 = 32'h0;
    step(2);
    keycode2 = 32'h0000_002C;
    step(1);
    chk("life rearm active", l_shot_active, 1);
    chk("life rearm x", l_shot_x, 337);
    keycode2 = 32'h0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
